// File: rtl/tff_mod_counter_if.sv
// Control/status bundle for the T-cell modulo counter.
// The master drives count controls and the slave (the counter) returns registered status.
interface tff_mod_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrapped;

  modport master (
    output en, up_dn, load, load_val,
    input  q, tc, wrapped
  );

  modport slave (
    input  en, up_dn, load, load_val,
    output q, tc, wrapped
  );
endinterface

// File: rtl/tff_mod_counter.sv
// Modulo-MODULUS up/down counter whose state bits are T cells (q ^= t).
// The only combinational work is building the per-bit toggle vector.
module tff_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic               clk,
  input  logic               reset,
  tff_mod_counter_if.slave   bus
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             wrapped_q, wrapped_d;

  logic [WIDTH-1:0] up_carry;
  logic [WIDTH-1:0] dn_borrow;
  logic [WIDTH-1:0] load_tgt;
  logic [WIDTH-1:0] tgl;
  logic             at_max;
  logic             at_zero;

  // Ripple-style enable chains: bit i toggles when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    up_carry     = '0;
    dn_borrow    = '0;
    up_carry[0]  = 1'b1;
    dn_borrow[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      up_carry[i]  = up_carry[i-1]  &  cnt_q[i-1];
      dn_borrow[i] = dn_borrow[i-1] & ~cnt_q[i-1];
    end
  end

  always_comb begin
    at_max   = (cnt_q == MAX_V);
    at_zero  = (cnt_q == '0);
    load_tgt = ({1'b0, bus.load_val} < MOD_W) ? bus.load_val : MAX_V;
  end

  // Every next state is expressed as a toggle pattern; wraps and loads toggle
  // exactly the bits that differ from the target value.
  always_comb begin
    tgl       = '0;
    tc_d      = 1'b0;
    wrapped_d = wrapped_q;
    if (bus.load) begin
      tgl       = cnt_q ^ load_tgt;
      wrapped_d = 1'b0;
    end else if (bus.en) begin
      if (bus.up_dn) begin
        if (at_max) begin
          tgl       = cnt_q;
          tc_d      = 1'b1;
          wrapped_d = 1'b1;
        end else begin
          tgl = up_carry;
        end
      end else begin
        if (at_zero) begin
          tgl       = cnt_q ^ MAX_V;
          tc_d      = 1'b1;
          wrapped_d = 1'b1;
        end else begin
          tgl = dn_borrow;
        end
      end
    end
    cnt_d = cnt_q ^ tgl;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      tc_q      <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      tc_q      <= tc_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign bus.q       = cnt_q;
  assign bus.tc      = tc_q;
  assign bus.wrapped = wrapped_q;

endmodule
